// File: rtl/aes_tiled_seq_pkg.sv
// Shared encodings and helpers for the sequenced AES tile controller.
package aes_tiled_seq_pkg;

    typedef enum logic [1:0] {
        CMD_SUB  = 2'b00,
        CMD_SBSR = 2'b01,
        CMD_MIX  = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int unsigned STEP_COUNT = 4;

    function automatic logic [31:0] state_word(input logic [127:0] s, input logic [1:0] idx);
        return s[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/aes_tiled_seq_if.sv
// Request/response and functional-unit bus of aes_tiled_seq.
// slave = the aes_tiled_seq side, master = requester plus external FU.
interface aes_tiled_seq_if;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_cmd;
    logic         req_dec;
    logic [127:0] req_state;
    logic [127:0] req_key;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_err;

    logic         fu_valid;
    logic         fu_dec;
    logic         fu_op_sb;
    logic         fu_op_sbsr;
    logic         fu_op_mix;
    logic         fu_hi;
    logic [31:0]  fu_rs1;
    logic [31:0]  fu_rs2;
    logic         fu_ready;
    logic [31:0]  fu_rd;

    modport slave (
        input  req_valid, req_cmd, req_dec, req_state, req_key, rsp_ready, fu_ready, fu_rd,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               fu_valid, fu_dec, fu_op_sb, fu_op_sbsr, fu_op_mix, fu_hi, fu_rs1, fu_rs2
    );

    modport master (
        output req_valid, req_cmd, req_dec, req_state, req_key, rsp_ready, fu_ready, fu_rd,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               fu_valid, fu_dec, fu_op_sb, fu_op_sbsr, fu_op_mix, fu_hi, fu_rs1, fu_rs2
    );
endinterface

// File: rtl/aes_tiled_seq_step.sv
// Combinational step decoder: maps (cmd, step, state) to the FU operands and op flags.
module aes_tiled_seq_step
    import aes_tiled_seq_pkg::*;
(
    input  cmd_e         cmd,
    input  logic [1:0]   step,
    input  logic [127:0] state,
    output logic         op_sb,
    output logic         op_sbsr,
    output logic         op_mix,
    output logic         hi,
    output logic [31:0]  rs1,
    output logic [31:0]  rs2
);

    always_comb begin
        op_sb   = 1'b0;
        op_sbsr = 1'b0;
        op_mix  = 1'b0;
        hi      = 1'b0;
        rs1     = '0;
        rs2     = '0;
        case (cmd)
            CMD_SUB: begin
                op_sb = 1'b1;
                rs1   = state_word(state, step);
            end
            CMD_SBSR: begin
                // Each column pair is visited twice: low half then high half.
                op_sbsr = 1'b1;
                rs1     = state_word(state, {step[1], 1'b0});
                rs2     = state_word(state, {step[1], 1'b1});
                hi      = step[0];
            end
            CMD_MIX: begin
                op_mix = 1'b1;
                rs1    = state_word(state, step);
                rs2    = state_word(state, step ^ 2'b01);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_tiled_seq.sv
// Sequencer issuing four FU operations per AES tile command and collecting the results.
// Optional AddRoundKey on the response is enabled by defining AES_TILED_SEQ_ARK_EN.
module aes_tiled_seq
    import aes_tiled_seq_pkg::*;
(
    input  logic          g_clk,
    input  logic          g_resetn,
    aes_tiled_seq_if.slave bus
);

    state_e       state_q;
    logic [1:0]   step_q;
    cmd_e         cmd_q;
    logic [127:0] src_q;
    logic [31:0]  res_q [STEP_COUNT];
`ifdef AES_TILED_SEQ_ARK_EN
    logic [127:0] key_q;
`endif

    logic         accept;
    logic         last_step;
    cmd_e         sel_cmd;
    logic [1:0]   sel_step;
    logic [127:0] sel_state;
    logic         nx_sb, nx_sbsr, nx_mix, nx_hi;
    logic [31:0]  nx_rs1, nx_rs2;
    logic [127:0] res_final;

    assign bus.req_ready = (state_q == ST_IDLE) && g_resetn;
    assign accept        = bus.req_valid && bus.req_ready;
    assign last_step     = (step_q == 2'(STEP_COUNT - 1));

    // Operands are registered one step ahead: from the request on accept, else for step+1.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_cmd   = cmd_e'(bus.req_cmd);
            sel_step  = '0;
            sel_state = bus.req_state;
        end else begin
            sel_cmd   = cmd_q;
            sel_step  = step_q + 2'd1;
            sel_state = src_q;
        end
    end

    aes_tiled_seq_step u_step (
        .cmd     (sel_cmd),
        .step    (sel_step),
        .state   (sel_state),
        .op_sb   (nx_sb),
        .op_sbsr (nx_sbsr),
        .op_mix  (nx_mix),
        .hi      (nx_hi),
        .rs1     (nx_rs1),
        .rs2     (nx_rs2)
    );

    always_comb begin
`ifdef AES_TILED_SEQ_ARK_EN
        res_final = {bus.fu_rd, res_q[2], res_q[1], res_q[0]} ^ key_q;
`else
        res_final = {bus.fu_rd, res_q[2], res_q[1], res_q[0]};
`endif
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q        <= ST_IDLE;
            step_q         <= '0;
            cmd_q          <= CMD_SUB;
            src_q          <= '0;
`ifdef AES_TILED_SEQ_ARK_EN
            key_q          <= '0;
`endif
            for (int unsigned i = 0; i < STEP_COUNT; i++) res_q[i] <= '0;
            bus.fu_valid   <= 1'b0;
            bus.fu_dec     <= 1'b0;
            bus.fu_op_sb   <= 1'b0;
            bus.fu_op_sbsr <= 1'b0;
            bus.fu_op_mix  <= 1'b0;
            bus.fu_hi      <= 1'b0;
            bus.fu_rs1     <= '0;
            bus.fu_rs2     <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q  <= cmd_e'(bus.req_cmd);
                        src_q  <= bus.req_state;
                        step_q <= '0;
`ifdef AES_TILED_SEQ_ARK_EN
                        key_q  <= bus.req_key;
`endif
                        if (cmd_e'(bus.req_cmd) == CMD_ILL) begin
                            state_q       <= ST_DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_data  <= bus.req_state;
                        end else begin
                            state_q        <= ST_ISSUE;
                            bus.fu_valid   <= 1'b1;
                            bus.fu_dec     <= bus.req_dec;
                            bus.fu_op_sb   <= nx_sb;
                            bus.fu_op_sbsr <= nx_sbsr;
                            bus.fu_op_mix  <= nx_mix;
                            bus.fu_hi      <= nx_hi;
                            bus.fu_rs1     <= nx_rs1;
                            bus.fu_rs2     <= nx_rs2;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.fu_ready) begin
                        res_q[step_q] <= bus.fu_rd;
                        if (last_step) begin
                            state_q        <= ST_DONE;
                            bus.fu_valid   <= 1'b0;
                            bus.fu_dec     <= 1'b0;
                            bus.fu_op_sb   <= 1'b0;
                            bus.fu_op_sbsr <= 1'b0;
                            bus.fu_op_mix  <= 1'b0;
                            bus.fu_hi      <= 1'b0;
                            bus.fu_rs1     <= '0;
                            bus.fu_rs2     <= '0;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_err    <= 1'b0;
                            bus.rsp_data   <= res_final;
                        end else begin
                            step_q         <= step_q + 2'd1;
                            bus.fu_op_sb   <= nx_sb;
                            bus.fu_op_sbsr <= nx_sbsr;
                            bus.fu_op_mix  <= nx_mix;
                            bus.fu_hi      <= nx_hi;
                            bus.fu_rs1     <= nx_rs1;
                            bus.fu_rs2     <= nx_rs2;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_tiled_seq.sv
// Directed self-checking bench for aes_tiled_seq with a behavioural FU stub (rd = rs1 + 0x10).
module tb_aes_tiled_seq;

    logic clk;
    logic rst_n;

    aes_tiled_seq_if bus ();

    aes_tiled_seq dut (
        .g_clk    (clk),
        .g_resetn (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // FU stub configuration and observation logs
    int          stall_cfg = 0;
    bit          fu_zero   = 0;
    bit          stub_ready = 0;
    int          stub_cnt  = 0;
    int          valid_cycles = 0;
    int          stall_changes = 0;
    bit          prev_stall = 0;
    logic [68:0] snap = '0;
    logic [68:0] cur;
    logic [31:0] log_rs1 [$];
    logic [31:0] log_rs2 [$];
    logic        log_hi  [$];
    logic [2:0]  log_op  [$];
    logic        log_dec [$];

    assign bus.fu_rd = fu_zero ? 32'h0 : bus.fu_rs1 + 32'h10;

    always @(negedge clk) begin
        if (!rst_n || !bus.fu_valid) begin
            stub_cnt   = 0;
            stub_ready = 0;
            prev_stall = 0;
        end else begin
            valid_cycles++;
            cur = {bus.fu_dec, bus.fu_op_sb, bus.fu_op_sbsr, bus.fu_op_mix, bus.fu_hi, bus.fu_rs1, bus.fu_rs2};
            if (prev_stall && cur !== snap) stall_changes++;
            if (stub_ready) stub_cnt = 0;
            if (stub_cnt < stall_cfg) begin
                stub_ready = 0;
                stub_cnt++;
            end else begin
                stub_ready = 1;
            end
            if (stub_ready) begin
                log_rs1.push_back(bus.fu_rs1);
                log_rs2.push_back(bus.fu_rs2);
                log_hi.push_back(bus.fu_hi);
                log_op.push_back({bus.fu_op_sb, bus.fu_op_sbsr, bus.fu_op_mix});
                log_dec.push_back(bus.fu_dec);
            end
            prev_stall = !stub_ready;
            snap = cur;
        end
        bus.fu_ready = stub_ready;
    end

    task automatic send(input logic [1:0] cmd, input logic dec, input logic [127:0] st, input logic [127:0] key);
        @(negedge clk);
        log_rs1.delete(); log_rs2.delete(); log_hi.delete(); log_op.delete(); log_dec.delete();
        valid_cycles  = 0;
        stall_changes = 0;
        check("req_ready_before_accept", bus.req_ready, 1'b1);
        bus.req_cmd   = cmd;
        bus.req_dec   = dec;
        bus.req_state = st;
        bus.req_key   = key;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble request inputs after the accept edge; they must be ignored.
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b11;
        bus.req_dec   = ~dec;
        bus.req_state = {4{32'hDEAD_BEEF}};
        bus.req_key   = ~key;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 100);
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        check("req_ready_in_rsp_handshake", bus.req_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after_handshake", bus.rsp_valid, 1'b0);
        check("req_ready_after_handshake", bus.req_ready, 1'b1);
    endtask

    task automatic check_ops(input string tag, input int n_exp,
                             input logic [31:0] e_rs1 [4], input logic [31:0] e_rs2 [4],
                             input logic e_hi [4], input logic [2:0] e_op, input logic e_dec);
        check({tag, "_op_count"}, log_rs1.size(), n_exp);
        for (int k = 0; k < 4; k++) begin
            if (k < log_rs1.size()) begin
                check($sformatf("%s_rs1_%0d", tag, k), log_rs1[k], e_rs1[k]);
                check($sformatf("%s_rs2_%0d", tag, k), log_rs2[k], e_rs2[k]);
                check($sformatf("%s_hi_%0d", tag, k), log_hi[k], e_hi[k]);
                check($sformatf("%s_op_%0d", tag, k), {log_op[k], log_dec[k]}, {e_op, e_dec});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [127:0] held;
        logic [127:0] exp_ark;
        logic [31:0] e_rs1 [4];
        logic [31:0] e_rs2 [4];
        logic        e_hi  [4];

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_dec   = 1'b0;
        bus.req_state = '0;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_fu_valid", bus.fu_valid, 1'b0);
        check("rst_fu_fields", {bus.fu_dec, bus.fu_op_sb, bus.fu_op_sbsr, bus.fu_op_mix, bus.fu_hi, bus.fu_rs1, bus.fu_rs2}, '0);
        check("rst_rsp_fields", {bus.rsp_err, bus.rsp_data}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", bus.req_ready, 1'b1);

        // SUB, stub returns rs1+0x10, no stall
        stall_cfg = 0;
        fu_zero   = 0;
        send(2'b00, 1'b0, {32'h4, 32'h3, 32'h2, 32'h1}, '0);
        wait_rsp(lat);
        check("sub_latency", lat, 5);
        check("sub_valid_cycles", valid_cycles, 4);
        e_rs1 = '{32'h1, 32'h2, 32'h3, 32'h4};
        e_rs2 = '{32'h0, 32'h0, 32'h0, 32'h0};
        e_hi  = '{1'b0, 1'b0, 1'b0, 1'b0};
        check_ops("sub", 4, e_rs1, e_rs2, e_hi, 3'b100, 1'b0);
        check("sub_rsp_data", bus.rsp_data, {32'h14, 32'h13, 32'h12, 32'h11});
        check("sub_rsp_err", bus.rsp_err, 1'b0);
        finish_rsp();

        // SBSR, decrypt, w = {A,B,C,D}
        send(2'b01, 1'b1, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, '0);
        wait_rsp(lat);
        check("sbsr_latency", lat, 5);
        e_rs1 = '{32'h11111111, 32'h11111111, 32'h33333333, 32'h33333333};
        e_rs2 = '{32'h22222222, 32'h22222222, 32'h44444444, 32'h44444444};
        e_hi  = '{1'b0, 1'b1, 1'b0, 1'b1};
        check_ops("sbsr", 4, e_rs1, e_rs2, e_hi, 3'b010, 1'b1);
        check("sbsr_rsp_data", bus.rsp_data, {32'h33333343, 32'h33333343, 32'h11111121, 32'h11111121});
        finish_rsp();

        // MIX with 3 stall cycles per op
        stall_cfg = 3;
        send(2'b10, 1'b0, {32'h400, 32'h300, 32'h200, 32'h100}, '0);
        wait_rsp(lat);
        check("mix_latency", lat, 17);
        check("mix_valid_cycles", valid_cycles, 16);
        check("mix_stall_stability", stall_changes, 0);
        e_rs1 = '{32'h100, 32'h200, 32'h300, 32'h400};
        e_rs2 = '{32'h200, 32'h100, 32'h400, 32'h300};
        e_hi  = '{1'b0, 1'b0, 1'b0, 1'b0};
        check_ops("mix", 4, e_rs1, e_rs2, e_hi, 3'b001, 1'b0);
        check("mix_rsp_data", bus.rsp_data, {32'h410, 32'h310, 32'h210, 32'h110});
        finish_rsp();
        stall_cfg = 0;

        // Illegal command: no FU op, error, data = state, key never applied
        send(2'b11, 1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '1);
        wait_rsp(lat);
        check("ill_latency", lat, 1);
        check("ill_no_fu_valid", valid_cycles, 0);
        check("ill_rsp_err", bus.rsp_err, 1'b1);
        check("ill_rsp_data", bus.rsp_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        finish_rsp();

        // AddRoundKey: key all ones, stub returns zero; response back-pressured
        fu_zero = 1;
`ifdef AES_TILED_SEQ_ARK_EN
        exp_ark = '1;
`else
        exp_ark = '0;
`endif
        send(2'b00, 1'b0, {32'h4, 32'h3, 32'h2, 32'h1}, '1);
        wait_rsp(lat);
        check("ark_latency", lat, 5);
        check("ark_rsp_data", bus.rsp_data, exp_ark);
        held = bus.rsp_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("ark_hold_data_%0d", c), bus.rsp_data, held);
            check($sformatf("ark_hold_ready_%0d", c), {bus.rsp_valid, bus.req_ready}, 2'b10);
        end
        finish_rsp();
        fu_zero = 0;

        // Reset pulsed during step 2 aborts the command
        stall_cfg = 2;
        send(2'b00, 1'b0, {32'h4, 32'h3, 32'h2, 32'h1}, '0);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.fu_valid && bus.fu_rs1 == 32'h3) seen = 1;
        end
        check("reached_step2", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_fu_valid", bus.fu_valid, 1'b0);
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_req_ready", bus.req_ready, 1'b0);
        check("abort_fu_fields", {bus.fu_op_sb, bus.fu_rs1, bus.fu_rs2}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_cycle_after_release", bus.req_ready, 1'b1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.fu_valid) seen++;
        end
        check("no_response_after_abort", seen, 0);
        stall_cfg = 0;

        // Recovery: a fresh command runs normally
        send(2'b00, 1'b0, {32'h40, 32'h30, 32'h20, 32'h10}, '0);
        wait_rsp(lat);
        check("recover_latency", lat, 5);
        check("recover_rsp_data", bus.rsp_data, {32'h50, 32'h40, 32'h30, 32'h20});
        finish_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_tiled_seq.md
AES_TILED_SEQ -- requirements
Module: aes_tiled_seq

Interface
REQ-001 SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port g_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports req_valid (in, 1) and req_ready (out, 1): request handshake.
REQ-004 SHALL have ports req_cmd (in, 2; 00=SUB, 01=SBSR, 10=MIX, 11=illegal), req_dec (in, 1; 1=decrypt), req_state (in, 128; word i = bits 32i+31:32i), req_key (in, 128).
REQ-005 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, 128), rsp_err (out, 1).
REQ-006 SHALL have functional-unit initiator ports: fu_valid, fu_dec, fu_op_sb, fu_op_sbsr, fu_op_mix, fu_hi (out, 1 each); fu_rs1 and fu_rs2 (out, 32 each); fu_ready (in, 1); fu_rd (in, 32).

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE, with a 2-bit step counter.
REQ-008 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready the block SHALL latch cmd, dec, state and key, clear step, and go to ISSUE (legal cmd) or DONE (illegal cmd).
REQ-009 In ISSUE, fu_valid SHALL be 1, with fu_dec=latched dec and exactly one fu_op_* asserted per cmd.
REQ-010 fu_valid and all fu_* outputs SHALL remain stable until fu_ready=1; an op completes on a cycle with fu_valid&&fu_ready.
REQ-011 Only one op SHALL be outstanding at a time; fu_ready while fu_valid=0 SHALL be ignored.
REQ-012 On completion, fu_rd SHALL be written to result word R[step], never to the latched source state.
REQ-013 Step table (k=0..3):
- SUB: rs1=w[k], rs2=0, hi=0.
- SBSR: rs1=w[2*(k>>1)], rs2=w[2*(k>>1)+1], hi=k[0].
- MIX: rs1=w[k], rs2=w[k^1], hi=0.
REQ-014 After step 3 completes, the FSM SHALL go to DONE; step SHALL NOT wrap within one command.
REQ-015 In DONE, rsp_valid SHALL be 1, and rsp_data and rsp_err SHALL hold until rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-016 An illegal cmd SHALL issue no FU op and SHALL return rsp_err=1 with rsp_data=latched state.
REQ-017 With fu_ready tied to fu_valid, latency SHALL be: accept at edge T; fu_valid high for cycles T+1..T+4; rsp_valid first high in cycle T+5.
REQ-018 FU stalls SHALL add latency cycle-for-cycle, with no result loss.
REQ-019 A new request SHALL NOT be accepted in the cycle rsp_ready completes the response; the earliest next acceptance is the following cycle.
REQ-020 Input changes on req_* outside the accept cycle SHALL have no effect.

Reset
REQ-021 Asserting g_resetn=0 SHALL immediately force IDLE and step=0.
REQ-022 While g_resetn=0: req_ready=0, rsp_valid=0, fu_valid=0, every fu_op_*=0, fu_hi=0, fu_dec=0, fu_rs1=fu_rs2=0, rsp_err=0, rsp_data=0, and result registers=0.
REQ-023 Reset asserted mid-command SHALL abort it, with no response.
REQ-024 req_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-025 Macro AES_TILED_SEQ_ARK_EN: when defined, rsp_data for legal cmds SHALL be R XOR latched key (AddRoundKey), with zero extra latency.
REQ-026 When AES_TILED_SEQ_ARK_EN is undefined, rsp_data SHALL be R; req_key remains a port and is ignored.
REQ-027 An illegal cmd SHALL never apply the key, in either configuration.

Structure
REQ-028 The shared package aes_tiled_seq_pkg SHALL hold the cmd encodings, the FSM state encodings, and the step-count constant (4).
REQ-029 The block SHALL contain one combinational sub-module, aes_tiled_seq_step, mapping (cmd, step, state) to (op flags, hi, rs1, rs2).
REQ-030 The FU SHALL be external and SHALL NOT be instantiated inside the block.

Verification
REQ-031 SUB, state words 0x00000001..0x00000004, FU stub returning rs1+0x10 with ready=valid -> rs1 sequence 1,2,3,4; fu_valid high for exactly 4 cycles; rsp_data words 0x11,0x12,0x13,0x14 at T+5.
REQ-032 SBSR, w={A,B,C,D} -> observed (rs1,rs2,hi) = (A,B,0), (A,B,1), (C,D,0), (C,D,1).
REQ-033 MIX with FU stub holding ready low 3 cycles per op -> fu_* stable during each stall; rs1/rs2 pairs (w0,w1), (w1,w0), (w2,w3), (w3,w2); rsp_valid at T+17.
REQ-034 cmd=11 -> no fu_valid; rsp_err=1; rsp_data=req_state at T+1.
REQ-035 ARK_EN defined, key=all 0xFF, stub returning 0 -> rsp_data all 0xFF; rsp_ready held low 5 cycles -> data stable and req_ready=0 throughout.
REQ-036 g_resetn pulsed low during step 2 -> fu_valid=0 and rsp_valid=0 immediately; no response; req_ready=1 in the first cycle after release.
